elevator_call_panel: RTL

Landing and cab button front end for the elevator controller. It edge-detects hall up/down buttons and latches them as pending calls, then presents them as the controller's `request_up`/`request_down` vectors. It accepts one cab destination per stop over a valid/ready handshake and drives `requested_floor`. It clears calls once the controller reports the car stationary and served at a floor, and it owns the call lamps and the door-open indication.

---
 rtl/elevator_pkg.sv | 14 +
 rtl/button_edge_detect.sv | 23 ++
 rtl/elevator_call_panel.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator controller and its call panel:
// direction encoding and the panel FSM states.
package elevator_pkg;

    localparam logic [1:0] GOING_UP   = 2'b11;
    localparam logic [1:0] GOING_DOWN = 2'b00;
    localparam logic [1:0] STATIONARY = 2'b01;

    typedef enum logic {
        S_WATCH = 1'b0,
        S_DOOR  = 1'b1
    } panel_state_t;

endpackage

// File: rtl/button_edge_detect.sv
// Rising-edge detector for a bank of level buttons; one-cycle pulse per press.
module button_edge_detect #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] i_btn,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_prev <= '0;
        end else begin
            r_prev <= i_btn;
        end
    end

    assign o_rise = i_btn & ~r_prev;

endmodule

// File: rtl/elevator_call_panel.sv
// Hall/cab call front end: latches hall presses, stops the car at called floors,
// takes one cab destination per stop and drives the door indication.
module elevator_call_panel
    import elevator_pkg::*;
#(
    parameter int N_FLOORS    = 10,
    parameter int FLOOR_W     = 4,
    parameter int DOOR_CYCLES = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N_FLOORS-1:0] hall_up_btn_i,
    input  logic [N_FLOORS-1:0] hall_down_btn_i,
    input  logic                cab_btn_valid_i,
    input  logic [FLOOR_W-1:0]  cab_btn_floor_i,
    output logic                cab_btn_ready_o,
    input  logic [FLOOR_W-1:0]  floor_i,
    input  logic [1:0]          direction_i,
    input  logic                request_served_i,
    output logic [N_FLOORS-1:0] request_up_o,
    output logic [N_FLOORS-1:0] request_down_o,
    output logic [FLOOR_W-1:0]  requested_floor_o,
    output logic [N_FLOORS-1:0] cab_lamp_o,
    output logic                door_open_o
);

    localparam int                  CNT_W      = $clog2(DOOR_CYCLES);
    localparam logic [CNT_W-1:0]    DWELL_LOAD = CNT_W'(DOOR_CYCLES - 1);
    localparam logic [31:0]         N_FLOORS_U = 32'(N_FLOORS);
    localparam logic [N_FLOORS-1:0] ONE_HOT0   = {{(N_FLOORS-1){1'b0}}, 1'b1};
    // No floor above the top for an up call, none below floor 0 for a down call.
    localparam logic [N_FLOORS-1:0] UP_MASK    = {1'b0, {(N_FLOORS-1){1'b1}}};
    localparam logic [N_FLOORS-1:0] DOWN_MASK  = {{(N_FLOORS-1){1'b1}}, 1'b0};

    panel_state_t        r_state;
    logic [N_FLOORS-1:0] r_up_calls;
    logic [N_FLOORS-1:0] r_down_calls;
    logic [N_FLOORS-1:0] r_cab_calls;
    logic [FLOOR_W-1:0]  r_stop_floor;
    logic [FLOOR_W-1:0]  r_req_floor;
    logic [CNT_W-1:0]    r_dwell;
    logic                r_cab_taken;
    logic                r_door;
    logic                r_ready;

    logic [N_FLOORS-1:0] w_up_rise_raw;
    logic [N_FLOORS-1:0] w_down_rise_raw;
    logic [N_FLOORS-1:0] w_up_rise;
    logic [N_FLOORS-1:0] w_down_rise;
    logic [N_FLOORS-1:0] w_here_mask;
    logic [N_FLOORS-1:0] w_stop_mask;
    logic [N_FLOORS-1:0] w_cab_mask;
    logic [N_FLOORS-1:0] w_hall_clr;
    logic                w_floor_ok;
    logic                w_cab_ok;
    logic                w_arrive;
    logic                w_xfer;
    logic                w_exit;

    button_edge_detect #(.WIDTH(N_FLOORS)) u_up_edge (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .i_btn  (hall_up_btn_i),
        .o_rise (w_up_rise_raw)
    );

    button_edge_detect #(.WIDTH(N_FLOORS)) u_down_edge (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .i_btn  (hall_down_btn_i),
        .o_rise (w_down_rise_raw)
    );

    assign w_up_rise   = w_up_rise_raw & UP_MASK;
    assign w_down_rise = w_down_rise_raw & DOWN_MASK;

    assign w_here_mask = ONE_HOT0 << floor_i;
    assign w_stop_mask = ONE_HOT0 << r_stop_floor;
    assign w_cab_mask  = ONE_HOT0 << cab_btn_floor_i;

    assign w_floor_ok = 32'(floor_i) < N_FLOORS_U;
    assign w_cab_ok   = (32'(cab_btn_floor_i) < N_FLOORS_U) && (cab_btn_floor_i != r_stop_floor);

    assign w_arrive = (r_state == S_WATCH) && (direction_i == STATIONARY) && w_floor_ok &&
                      (|((r_up_calls | r_down_calls | r_cab_calls) & w_here_mask));
    assign w_xfer   = (r_state == S_DOOR) && cab_btn_valid_i && r_ready;
    assign w_exit   = (r_state == S_DOOR) &&
                      ((request_served_i && r_cab_taken) || (r_dwell == '0));

    assign w_hall_clr = w_exit ? w_stop_mask : '0;

    // A fresh press in the exit cycle wins over the clear of the served floor.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_up_calls   <= '0;
            r_down_calls <= '0;
        end else begin
            r_up_calls   <= (r_up_calls & ~w_hall_clr) | w_up_rise;
            r_down_calls <= (r_down_calls & ~w_hall_clr) | w_down_rise;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= S_WATCH;
            r_cab_calls  <= '0;
            r_stop_floor <= '0;
            r_req_floor  <= '0;
            r_dwell      <= '0;
            r_cab_taken  <= 1'b0;
            r_door       <= 1'b0;
            r_ready      <= 1'b0;
        end else begin
            case (r_state)
                S_WATCH: begin
                    if (w_arrive) begin
                        r_state      <= S_DOOR;
                        r_stop_floor <= floor_i;
                        r_req_floor  <= floor_i;
                        r_dwell      <= DWELL_LOAD;
                        r_cab_calls  <= r_cab_calls & ~w_here_mask;
                        r_cab_taken  <= 1'b0;
                        r_door       <= 1'b1;
                        r_ready      <= 1'b1;
                    end
                end
                S_DOOR: begin
                    if (r_dwell != '0) begin
                        r_dwell <= r_dwell - 1'b1;
                    end
                    // Invalid destinations are still consumed so the panel stops offering.
                    if (w_xfer) begin
                        r_cab_taken <= 1'b1;
                        r_ready     <= 1'b0;
                        if (w_cab_ok) begin
                            r_req_floor <= cab_btn_floor_i;
                            r_cab_calls <= r_cab_calls | w_cab_mask;
                        end
                    end
                    if (w_exit) begin
                        r_state     <= S_WATCH;
                        r_cab_taken <= 1'b0;
                        r_door      <= 1'b0;
                        r_ready     <= 1'b0;
                    end
                end
                default: r_state <= S_WATCH;
            endcase
        end
    end

    assign request_up_o      = r_up_calls;
    assign request_down_o    = r_down_calls;
    assign cab_lamp_o        = r_cab_calls;
    assign requested_floor_o = r_req_floor;
    assign door_open_o       = r_door;
    assign cab_btn_ready_o   = r_ready;

endmodule
